// File: rtl/blackjack_main.sv
// blackjack_main: single-player blackjack against an automatic dealer for the DE2-115 board.
// Optional build macro DEALER_HIDE_EN: show only the dealer's first card until the dealer plays.
module blackjack_main #(
  parameter logic [19:0] SIM_DEBOUNCE_TIMER = 20'd1_000_000,
  parameter logic [26:0] SIM_GAME_TIMER     = 27'd50_000_000
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  output logic [17:0] LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);
  typedef enum logic [2:0] {
    S_SHUFFLE = 3'd0, S_DEAL_P1 = 3'd1, S_DEAL_D1 = 3'd2, S_DEAL_P2 = 3'd3,
    S_DEAL_D2 = 3'd4, S_PLAYER  = 3'd5, S_DEALER  = 3'd6, S_RESULT  = 3'd7
  } state_t;

  function automatic logic [3:0] f_card_val(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  function automatic logic [4:0] f_add_sat(input logic [4:0] hard, input logic [3:0] val);
    logic [5:0] sum;
    sum = {1'b0, hard} + {2'b00, val};
    return (sum > 6'd31) ? 5'd31 : sum[4:0];
  endfunction

  function automatic logic [4:0] f_total(input logic [4:0] hard, input logic ace);
    return (ace && (hard <= 5'd11)) ? hard + 5'd10 : hard;
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Returns {tens, units} segment patterns; a zero tens digit is blanked.
  function automatic logic [13:0] f_show(input logic [4:0] total);
    logic [3:0] tens;
    logic [3:0] units;
    if (total >= 5'd30) begin
      tens = 4'd3; units = 4'(total - 5'd30);
    end else if (total >= 5'd20) begin
      tens = 4'd2; units = 4'(total - 5'd20);
    end else if (total >= 5'd10) begin
      tens = 4'd1; units = 4'(total - 5'd10);
    end else begin
      tens = 4'd0; units = 4'(total);
    end
    return {(tens == 4'd0) ? 7'h7F : f_seg(tens), f_seg(units)};
  endfunction

  state_t      r_state, w_state_nx;
  logic [26:0] r_timer;
  logic [3:0]  r_rank;
  logic [4:0]  r_p_hard, r_d_hard;
  logic        r_p_ace, r_d_ace;
  logic        r_win, r_lose, r_push, r_bust;
  logic [19:0] r_db_cnt [2];
  logic [1:0]  r_press;

  logic        w_rst_n, w_hit, w_stay, w_paced, w_tick;
  logic        w_draw_p, w_draw_d, w_bust, w_eval, w_clear;
  logic [3:0]  w_card, w_card_val, w_rank_nx;
  logic [4:0]  w_p_hard_nx, w_d_hard_nx;
  logic        w_p_ace_nx, w_d_ace_nx;
  logic [4:0]  w_p_total, w_d_total, w_p_total_nx, w_d_show;
  logic        w_unused_key3;

  assign w_rst_n       = KEY[0];
  assign w_unused_key3 = KEY[3];
  assign w_hit         = r_press[0];
  assign w_stay        = r_press[1];

  // Key debounce: count consecutive low cycles, pulse once, re-arm only after release.
  always_ff @(posedge CLOCK_50) begin
    for (int k = 0; k < 2; k++) begin
      if (!w_rst_n || KEY[k+1]) begin
        r_db_cnt[k] <= '0;
        r_press[k]  <= 1'b0;
      end else begin
        r_press[k] <= (r_db_cnt[k] == SIM_DEBOUNCE_TIMER - 20'd1);
        if (r_db_cnt[k] != SIM_DEBOUNCE_TIMER) r_db_cnt[k] <= r_db_cnt[k] + 20'd1;
      end
    end
  end

  assign w_paced = (r_state != S_PLAYER) && (r_state != S_RESULT);
  assign w_tick  = w_paced && (r_timer == SIM_GAME_TIMER - 27'd1);

  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n || !w_paced || w_tick) r_timer <= '0;
    else                                r_timer <= r_timer + 27'd1;
  end

  assign w_card       = r_rank;
  assign w_card_val   = f_card_val(w_card);
  assign w_rank_nx    = (r_rank > 4'd8) ? r_rank - 4'd8 : r_rank + 4'd5;
  assign w_p_hard_nx  = f_add_sat(r_p_hard, w_card_val);
  assign w_d_hard_nx  = f_add_sat(r_d_hard, w_card_val);
  assign w_p_ace_nx   = r_p_ace | (w_card == 4'd1);
  assign w_d_ace_nx   = r_d_ace | (w_card == 4'd1);
  assign w_p_total    = f_total(r_p_hard, r_p_ace);
  assign w_d_total    = f_total(r_d_hard, r_d_ace);
  assign w_p_total_nx = f_total(w_p_hard_nx, w_p_ace_nx);

  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) r_state <= S_SHUFFLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_SHUFFLE: if (w_tick) w_state_nx = S_DEAL_P1;
      S_DEAL_P1: if (w_tick) w_state_nx = S_DEAL_D1;
      S_DEAL_D1: if (w_tick) w_state_nx = S_DEAL_P2;
      S_DEAL_P2: if (w_tick) w_state_nx = S_DEAL_D2;
      S_DEAL_D2: if (w_tick) w_state_nx = S_PLAYER;
      S_PLAYER: begin
        if (w_stay)      w_state_nx = S_DEALER;
        else if (w_bust) w_state_nx = S_RESULT;
      end
      S_DEALER:  if (w_eval) w_state_nx = S_RESULT;
      S_RESULT:  if (w_hit)  w_state_nx = S_SHUFFLE;
      default:   w_state_nx = S_SHUFFLE;
    endcase
  end

  // Stay outranks Hit in PLAYER, so a simultaneous pair draws nothing.
  always_comb begin
    w_draw_p = 1'b0;
    w_draw_d = 1'b0;
    w_bust   = 1'b0;
    w_eval   = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      S_DEAL_P1, S_DEAL_P2: w_draw_p = w_tick;
      S_DEAL_D1, S_DEAL_D2: w_draw_d = w_tick;
      S_PLAYER: begin
        w_draw_p = w_hit && !w_stay;
        w_bust   = w_draw_p && (w_p_total_nx > 5'd21);
      end
      S_DEALER: begin
        w_draw_d = w_tick && (w_d_total < 5'd17);
        w_eval   = w_tick && (w_d_total >= 5'd17);
      end
      S_RESULT: w_clear = w_hit;
      default:  ;
    endcase
  end

  // The deck pointer survives new rounds; only reset rewinds it.
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n)                 r_rank <= 4'd1;
    else if (w_draw_p || w_draw_d) r_rank <= w_rank_nx;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n || w_clear) begin
      r_p_hard <= '0;
      r_p_ace  <= 1'b0;
      r_d_hard <= '0;
      r_d_ace  <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
      r_push   <= 1'b0;
      r_bust   <= 1'b0;
    end else begin
      if (w_draw_p) begin
        r_p_hard <= w_p_hard_nx;
        r_p_ace  <= w_p_ace_nx;
      end
      if (w_draw_d) begin
        r_d_hard <= w_d_hard_nx;
        r_d_ace  <= w_d_ace_nx;
      end
      if (w_bust) begin
        r_lose <= 1'b1;
        r_bust <= 1'b1;
      end
      if (w_eval) begin
        r_win  <= (w_d_total > 5'd21) || (w_p_total > w_d_total);
        r_lose <= (w_d_total <= 5'd21) && (w_p_total < w_d_total);
        r_push <= (w_d_total <= 5'd21) && (w_p_total == w_d_total);
      end
    end
  end

`ifdef DEALER_HIDE_EN
  logic [3:0] r_d1_val;

  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n || w_clear)
      r_d1_val <= '0;
    else if ((r_state == S_DEAL_D1) && w_tick)
      r_d1_val <= (w_card == 4'd1) ? 4'd11 : w_card_val;
  end

  assign w_d_show = ((r_state == S_DEAL_D2) || (r_state == S_PLAYER)) ? {1'b0, r_d1_val} : w_d_total;
`else
  assign w_d_show = w_d_total;
`endif

  assign {HEX1, HEX0} = f_show(w_p_total);
  assign {HEX5, HEX4} = f_show(w_d_show);
  assign LEDR         = {10'd0, 1'b0, r_state, r_bust, r_push, r_lose, r_win};

endmodule

// File: tb/tb_blackjack_main.sv
// Bench for blackjack_main: card-list game model checked every cycle, plus scripted rounds.
module tb_blackjack_main;
  localparam int T = 10;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic [3:0]  key;
  logic [17:0] ledr;
  logic [6:0]  hex0, hex1, hex4, hex5;

  blackjack_main #(
    .SIM_DEBOUNCE_TIMER(20'd5),
    .SIM_GAME_TIMER    (27'd10)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .LEDR    (ledr),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX4    (hex4),
    .HEX5    (hex5)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Game model: hands are lists of card ranks, totals recomputed from the list.
  int m_state, m_timer, m_deck;
  bit m_win, m_lose, m_push, m_bust;
  int p_cards[$];
  int d_cards[$];
  int lowcnt[2];
  bit pulse[2];
  bit m_valid = 1'b0;

  function automatic int card_val(int r);
    return (r > 10) ? 10 : r;
  endfunction

  function automatic int hand_total(input int cards[$]);
    int hard = 0;
    bit ace = 1'b0;
    foreach (cards[i]) begin
      hard += card_val(cards[i]);
      if (cards[i] == 1) ace = 1'b1;
    end
    if (hard > 31) hard = 31;
    if (ace && hard + 10 <= 21) return hard + 10;
    return hard;
  endfunction

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] tens_seg(int t);
    return (t < 10) ? 7'h7F : seg(t / 10);
  endfunction

  function automatic int draw();
    int r;
    r = m_deck;
    m_deck = ((m_deck - 1 + 5) % 13) + 1;
    return r;
  endfunction

  task automatic model_step();
    bit hit, stay, paced, tick;
    int pt, dt;
    if (!key[0]) begin
      m_state = 0; m_timer = 0; m_deck = 1;
      p_cards.delete(); d_cards.delete();
      m_win = 0; m_lose = 0; m_push = 0; m_bust = 0;
      lowcnt[0] = 0; lowcnt[1] = 0; pulse[0] = 0; pulse[1] = 0;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    hit  = pulse[0];
    stay = pulse[1];
    for (int k = 0; k < 2; k++) begin
      lowcnt[k] = key[k+1] ? 0 : lowcnt[k] + 1;
      pulse[k]  = (lowcnt[k] == N);
    end
    paced   = !(m_state == 5 || m_state == 7);
    tick    = paced && (m_timer == T - 1);
    m_timer = (paced && !tick) ? m_timer + 1 : 0;
    case (m_state)
      0: if (tick) m_state = 1;
      1: if (tick) begin p_cards.push_back(draw()); m_state = 2; end
      2: if (tick) begin d_cards.push_back(draw()); m_state = 3; end
      3: if (tick) begin p_cards.push_back(draw()); m_state = 4; end
      4: if (tick) begin d_cards.push_back(draw()); m_state = 5; end
      5: begin
        if (stay) m_state = 6;
        else if (hit) begin
          p_cards.push_back(draw());
          if (hand_total(p_cards) > 21) begin
            m_bust = 1; m_lose = 1; m_state = 7;
          end
        end
      end
      6: if (tick) begin
        dt = hand_total(d_cards);
        if (dt < 17) d_cards.push_back(draw());
        else begin
          pt = hand_total(p_cards);
          if (dt > 21)       m_win  = 1;
          else if (pt > dt)  m_win  = 1;
          else if (pt == dt) m_push = 1;
          else               m_lose = 1;
          m_state = 7;
        end
      end
      7: if (hit) begin
        p_cards.delete(); d_cards.delete();
        m_win = 0; m_lose = 0; m_push = 0; m_bust = 0;
        m_state = 0;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [17:0] e;
    int pt, dt;
    @(negedge clk);
    if (m_valid) begin
      e = '0;
      e[7:4] = 4'(m_state);
      e[3] = m_bust; e[2] = m_push; e[1] = m_lose; e[0] = m_win;
      pt = hand_total(p_cards);
      dt = hand_total(d_cards);
      chk("ledr", ledr, e);
      chk("hex0", {11'd0, hex0}, {11'd0, seg(pt % 10)});
      chk("hex1", {11'd0, hex1}, {11'd0, tens_seg(pt)});
      chk("hex4", {11'd0, hex4}, {11'd0, seg(dt % 10)});
      chk("hex5", {11'd0, hex5}, {11'd0, tens_seg(dt)});
    end
  end

  task automatic tick_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int k, int len);
    key[k] = 1'b0;
    tick_n(len);
    key[k] = 1'b1;
    tick_n(2);
  endtask

  task automatic wait_state(int code, int budget, string name);
    int c = 0;
    while (m_state != code && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (m_state != code) begin
      n_fail++;
      $display("FAIL %s: timeout, model state %0d, required %0d", name, m_state, code);
    end
  endtask

  task automatic lit_hands(string name, logic [6:0] h1, logic [6:0] h0, logic [6:0] h5, logic [6:0] h4);
    chk({name, "_hex1"}, {11'd0, hex1}, {11'd0, h1});
    chk({name, "_hex0"}, {11'd0, hex0}, {11'd0, h0});
    chk({name, "_hex5"}, {11'd0, hex5}, {11'd0, h5});
    chk({name, "_hex4"}, {11'd0, hex4}, {11'd0, h4});
  endtask

  initial begin
    int run[2];
    key = 4'hE;
    tick_n(15);
    chk("reset_ledr", ledr, 18'd0);
    lit_hands("reset", 7'h7F, 7'h40, 7'h7F, 7'h40);

    // Round 1: player A,J = 21; dealer 6,3 = 9.
    key[0] = 1'b1;
    wait_state(5, 80, "deal1");
    chk("deal1_state", {14'd0, ledr[7:4]}, 18'd5);
    lit_hands("deal1", 7'h24, 7'h79, 7'h7F, 7'h10);

    press(1, 5);
    lit_hands("hit8", 7'h79, 7'h10, 7'h7F, 7'h10);
    chk("hit8_state", {14'd0, ledr[7:4]}, 18'd5);
    press(1, 3);
    tick_n(3);
    lit_hands("glitch", 7'h79, 7'h10, 7'h7F, 7'h10);

    press(2, 5);
    wait_state(7, 60, "dealer1");
    chk("push_ledr", {10'd0, ledr[7:0]}, 18'h74);
    lit_hands("push", 7'h79, 7'h10, 7'h79, 7'h10);

    // Round 2: player 5,2 = 7; dealer 10,7 = 17.
    press(1, 5);
    wait_state(5, 80, "deal2");
    lit_hands("deal2", 7'h7F, 7'h78, 7'h79, 7'h78);
    press(1, 5);
    lit_hands("hit12", 7'h79, 7'h78, 7'h79, 7'h78);
    press(1, 5);
    lit_hands("hit4", 7'h24, 7'h79, 7'h79, 7'h78);
    press(2, 5);
    wait_state(7, 60, "dealer2");
    chk("win_ledr", {10'd0, ledr[7:0]}, 18'h71);

    // Round 3: reset while the dealer is thinking.
    press(1, 5);
    wait_state(5, 80, "deal3");
    press(2, 5);
    chk("dealer3_state", {14'd0, ledr[7:4]}, 18'd6);
    tick_n(3);
    key[0] = 1'b0;
    tick_n(1);
    chk("midreset_ledr", ledr, 18'd0);
    lit_hands("midreset", 7'h7F, 7'h40, 7'h7F, 7'h40);
    key[0] = 1'b1;
    wait_state(5, 80, "deal4");
    lit_hands("deal4", 7'h24, 7'h79, 7'h7F, 7'h10);

    // Random key activity with occasional resets.
    run[0] = 0; run[1] = 0;
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (run[k] == 0) begin
          key[k+1] = ~key[k+1];
          run[k] = key[k+1] ? $urandom_range(5, 60) : $urandom_range(1, 14);
        end
        run[k]--;
      end
      key[0] = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
